// File: rtl/soc_top.sv
// soc_top: single-cycle RV32I core with tightly coupled instruction and data
// memories. Every rising edge of clk fetches, decodes, executes and retires
// one instruction. State is reachable only through hierarchy:
//   u_itcm.mem     instruction words; no write port, preloaded through hierarchy
//   u_dtcm.mem     data words; combinational read, word write on the clock edge
//   u_regfile.regs x0..x31
//   pc             program counter
// Ports:
//   clk    system clock, rising-edge active
//   rst_n  asynchronous active-low reset (pc and regs cleared, memories kept)

module soc_itcm #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic [31:0] addr,
  output logic [31:0] rdata
);
  logic [31:0] mem [0:DEPTH-1];
  logic        unused_addr;

  assign rdata       = mem[addr[AW+1:2]];
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
endmodule

module soc_dtcm #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [31:0] mem [0:DEPTH-1];
  logic        unused_addr;

  // Contents deliberately have no reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr[AW+1:2]] <= wdata;
  end

  assign rdata       = mem[addr[AW+1:2]];
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
endmodule

module soc_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] regs [0:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];
endmodule

module soc_top #(
  parameter int ITCM_DEPTH = 1024,
  parameter int DTCM_DEPTH = 1024
) (
  input logic clk,
  input logic rst_n
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] pc, next_pc, pc_plus4, instr;
  logic [31:0] rs1_val, rs2_val, dm_addr, dm_rdata;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic        rf_we, dm_we, br_taken;
  logic [31:0] rf_wd;

  // alt selects SUB for funct3 000 and arithmetic shift for funct3 101
  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (f3)
      3'b000:  r = alt ? (a - b) : (a + b);
      3'b001:  r = a << b[4:0];
      3'b010:  r = {31'd0, $signed(a) < $signed(b)};
      3'b011:  r = {31'd0, a < b};
      3'b100:  r = a ^ b;
      3'b101:  r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  soc_itcm #(.DEPTH(ITCM_DEPTH)) u_itcm (
    .addr  (pc),
    .rdata (instr)
  );

  soc_regfile u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs1),
    .ra2   (rs2),
    .rd1   (rs1_val),
    .rd2   (rs2_val),
    .we    (rf_we),
    .wa    (rd),
    .wd    (rf_wd)
  );

  // Gating with rst_n keeps a store at pc 0 from landing while reset is held.
  soc_dtcm #(.DEPTH(DTCM_DEPTH)) u_dtcm (
    .clk   (clk),
    .we    (dm_we & rst_n),
    .addr  (dm_addr),
    .wdata (rs2_val),
    .rdata (dm_rdata)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign pc_plus4 = pc + 32'd4;
  assign dm_addr  = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val <  rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Anything not decoded below falls through to the defaults, i.e. a NOP.
  always_comb begin
    next_pc = pc_plus4;
    rf_we   = 1'b0;
    rf_wd   = '0;
    dm_we   = 1'b0;
    case (opcode)
      OP_LUI: begin
        rf_we = 1'b1;
        rf_wd = imm_u;
      end
      OP_AUIPC: begin
        rf_we = 1'b1;
        rf_wd = pc + imm_u;
      end
      OP_JAL: begin
        rf_we   = 1'b1;
        rf_wd   = pc_plus4;
        next_pc = pc + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          rf_we   = 1'b1;
          rf_wd   = pc_plus4;
          next_pc = (rs1_val + imm_i) & ~32'd1;
        end
      end
      OP_BRANCH: begin
        if (br_taken) next_pc = pc + imm_b;
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          rf_we = 1'b1;
          rf_wd = dm_rdata;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) dm_we = 1'b1;
      end
      OP_IMM: begin
        // ADDI has no subtract form, so alt only applies to the right shift.
        if ((funct3 == 3'b001 && funct7 == 7'b0000000) ||
            (funct3 == 3'b101 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) ||
            (funct3 != 3'b001 && funct3 != 3'b101)) begin
          rf_we = 1'b1;
          rf_wd = alu(funct3, (funct3 == 3'b101) && funct7[5], rs1_val, imm_i);
        end
      end
      OP_REG: begin
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          rf_we = 1'b1;
          rf_wd = alu(funct3, funct7[5], rs1_val, rs2_val);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= '0;
    else        pc <= next_pc;
  end
endmodule

// File: tb/tb_soc_top.sv
module tb_soc_top;
  localparam int IW = 1024;
  localparam int DW = 1024;
  localparam int NPROG = 3;
  localparam int NCYC = 100;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  logic [31:0] img [IW];
  logic [31:0] m_pc;
  logic [31:0] m_x [32];
  logic [31:0] m_d [DW];

  soc_top #(.ITCM_DEPTH(IW), .DTCM_DEPTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  task automatic load_img();
    for (int i = 0; i < IW; i++) dut.u_itcm.mem[i] = img[i];
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Random instruction over x0..x7; control transfers stay forward or land
  // at absolute word targets inside the program body, loads and stores use
  // words 0..15 which the preamble clears.
  function automatic logic [31:0] gen_instr();
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm;
    logic [31:0] w, res;
    rd  = 5'($urandom_range(0, 7));
    r1  = 5'($urandom_range(0, 7));
    r2  = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    w   = $urandom;
    case ($urandom_range(0, 2))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    case ($urandom_range(0, 9))
      0: res = enc_r(f7, r2, r1, f3, rd);
      1: res = enc_i(imm, r1, f3, rd, 7'h13);
      2: res = enc_i({f7, imm[4:0]}, r1, f3, rd, 7'h13);
      3: res = {w[31:12], rd, ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17};
      4: res = enc_s({5'd0, 5'($urandom_range(0, 15)), 2'd0}, r2, 5'd0,
                     ($urandom_range(0, 3) == 0) ? 3'd0 : 3'd2);
      5: res = enc_i({5'd0, 5'($urandom_range(0, 15)), 2'd0}, 5'd0,
                     ($urandom_range(0, 3) == 0) ? 3'd1 : 3'd2, rd, 7'h03);
      6: res = enc_b({8'd0, 3'($urandom_range(1, 4)), 2'd0}, r2, r1, f3);
      7: res = enc_j({16'd0, 3'($urandom_range(1, 4)), 2'd0}, rd);
      8: res = enc_i({3'd0, 7'($urandom_range(16, 63)), 1'b0, 1'($urandom_range(0, 1))},
                     5'd0, 3'd0, rd, 7'h67);
      default: res = {w[31:7], ($urandom_range(0, 1) == 1) ? 7'h0F : 7'h73};
    endcase
    return res;
  endfunction

  // ISA-level interpreter: one architectural step from m_pc.
  task automatic model_step();
    logic [31:0] ins, a, b, ii, is, ib, ij, npc, val, ea;
    logic [4:0]  rd, sha;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        wen, tk;
    int          idx;
    idx = int'((m_pc >> 2) % IW);
    ins = img[idx];
    rd  = ins[11:7];
    f3  = ins[14:12];
    f7  = ins[31:25];
    a   = m_x[ins[19:15]];
    b   = m_x[ins[24:20]];
    ii  = 32'($signed(ins) >>> 20);
    is  = (ii & ~32'h1F) | ((ins >> 7) & 32'h1F);
    ib  = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    ij  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    npc = m_pc + 4;
    wen = 1'b0;
    val = '0;
    case (ins[6:0])
      7'h37: begin wen = 1'b1; val = ins & 32'hFFFFF000; end
      7'h17: begin wen = 1'b1; val = m_pc + (ins & 32'hFFFFF000); end
      7'h6F: begin wen = 1'b1; val = m_pc + 4; npc = m_pc + ij; end
      7'h67: if (f3 == 3'd0) begin wen = 1'b1; val = m_pc + 4; npc = (a + ii) & 32'hFFFFFFFE; end
      7'h63: begin
        tk = 1'b0;
        if (f3 == 3'd0) tk = (a == b);
        if (f3 == 3'd1) tk = (a != b);
        if (f3 == 3'd4) tk = ($signed(a) < $signed(b));
        if (f3 == 3'd5) tk = !($signed(a) < $signed(b));
        if (f3 == 3'd6) tk = (a < b);
        if (f3 == 3'd7) tk = !(a < b);
        if (tk) npc = m_pc + ib;
      end
      7'h03: if (f3 == 3'd2) begin
        ea = a + ii;
        wen = 1'b1;
        val = m_d[int'((ea >> 2) % DW)];
      end
      7'h23: if (f3 == 3'd2) begin
        ea = a + is;
        m_d[int'((ea >> 2) % DW)] = b;
      end
      7'h13: begin
        sha = ins[24:20];
        wen = 1'b1;
        case (f3)
          3'd0: val = a + ii;
          3'd2: val = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
          3'd3: val = (a < ii) ? 32'd1 : 32'd0;
          3'd4: val = a ^ ii;
          3'd6: val = a | ii;
          3'd7: val = a & ii;
          3'd1: if (f7 == 7'h00) val = a << sha; else wen = 1'b0;
          default:
            if (f7 == 7'h00) val = a >> sha;
            else if (f7 == 7'h20) val = 32'($signed(a) >>> sha);
            else wen = 1'b0;
        endcase
      end
      7'h33: begin
        sha = b[4:0];
        wen = 1'b1;
        if (f7 == 7'h20 && f3 == 3'd0) val = a - b;
        else if (f7 == 7'h20 && f3 == 3'd5) val = 32'($signed(a) >>> sha);
        else if (f7 != 7'h00) wen = 1'b0;
        else case (f3)
          3'd0: val = a + b;
          3'd1: val = a << sha;
          3'd2: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: val = (a < b) ? 32'd1 : 32'd0;
          3'd4: val = a ^ b;
          3'd5: val = a >> sha;
          3'd6: val = a | b;
          default: val = a & b;
        endcase
      end
      default: begin
      end
    endcase
    if (wen && rd != 5'd0) m_x[rd] = val;
    m_pc = npc;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < IW; i++) img[i] = 32'h00000013;
    img[0]  = 32'h100137b7;                                   // lui  x15,0x10013
    img[1]  = 32'h00578793;                                   // addi x15,x15,5
    img[2]  = enc_s(12'd0, 5'd15, 5'd0, 3'd2);                // sw   x15,0(x0)
    img[3]  = enc_i(12'd0, 5'd0, 3'd2, 5'd10, 7'h03);         // lw   x10,0(x0)
    img[4]  = enc_j(21'd8, 5'd1);                             // jal  x1,+8
    img[5]  = enc_j(21'd8, 5'd0);                             // jal  x0,+8
    img[6]  = enc_i(12'd0, 5'd1, 3'd0, 5'd0, 7'h67);          // jalr x0,0(x1)
    img[7]  = enc_i(12'd3, 5'd0, 3'd0, 5'd5, 7'h13);          // addi x5,x0,3
    img[8]  = enc_i(12'hFFF, 5'd5, 3'd0, 5'd5, 7'h13);        // addi x5,x5,-1
    img[9]  = enc_b(13'h1FFC, 5'd0, 5'd5, 3'd1);              // bne  x5,x0,-4
    img[10] = enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'h13);          // addi x0,x0,7
    img[11] = enc_j(21'd0, 5'd0);                             // jal  x0,0
    load_img();

    @(negedge clk);
    chk("reset pc", dut.pc, 32'h0);
    chk("reset x15", dut.u_regfile.regs[15], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    step();
    chk("lui x15", dut.u_regfile.regs[15], 32'h10013000);
    chk("lui pc", dut.pc, 32'h4);
    step();
    chk("addi x15", dut.u_regfile.regs[15], 32'h10013005);
    chk("addi pc", dut.pc, 32'h8);
    step();
    chk("sw mem0", dut.u_dtcm.mem[0], 32'h10013005);
    chk("sw pc", dut.pc, 32'hC);
    step();
    chk("lw x10", dut.u_regfile.regs[10], 32'h10013005);
    chk("lw pc", dut.pc, 32'h10);
    step();
    chk("jal x1", dut.u_regfile.regs[1], 32'h14);
    chk("jal pc", dut.pc, 32'h18);
    step();
    chk("jalr pc", dut.pc, 32'h14);
    chk("jalr x0", dut.u_regfile.regs[0], 32'h0);
    step();
    chk("jal x0 pc", dut.pc, 32'h1C);
    step();
    chk("loop init x5", dut.u_regfile.regs[5], 32'd3);
    for (int it = 1; it <= 3; it++) begin
      step();
      chk($sformatf("loop dec x5 it%0d", it), dut.u_regfile.regs[5], 32'(3 - it));
      step();
      chk($sformatf("loop bne pc it%0d", it), dut.pc, (it < 3) ? 32'h20 : 32'h28);
    end
    step();
    chk("addi x0 stays 0", dut.u_regfile.regs[0], 32'h0);
    chk("addi x0 pc", dut.pc, 32'h2C);
    step();
    chk("self jal pc", dut.pc, 32'h2C);

    #3 rst_n = 1'b0;
    #1;
    chk("async reset pc", dut.pc, 32'h0);
    chk("async reset x15", dut.u_regfile.regs[15], 32'h0);
    chk("async reset x1", dut.u_regfile.regs[1], 32'h0);
    chk("async reset x5", dut.u_regfile.regs[5], 32'h0);
    step();
    chk("held reset pc", dut.pc, 32'h0);
    chk("dtcm kept", dut.u_dtcm.mem[0], 32'h10013005);
    rst_n = 1'b1;
    step();
    chk("restart lui x15", dut.u_regfile.regs[15], 32'h10013000);
    chk("restart pc", dut.pc, 32'h4);

    for (int p = 0; p < NPROG; p++) begin
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < IW; i++) img[i] = 32'h00000013;
      for (int i = 0; i < 16; i++) img[i] = enc_s(12'(4 * i), 5'd0, 5'd0, 3'd2);
      for (int i = 16; i < 64; i++) img[i] = gen_instr();
      load_img();
      m_pc = '0;
      for (int i = 0; i < 32; i++) m_x[i] = '0;
      for (int i = 0; i < DW; i++) m_d[i] = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < NCYC; c++) begin
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk($sformatf("rnd p%0d c%0d pc", p, c), dut.pc, m_pc);
        for (int r = 0; r < 8; r++)
          chk($sformatf("rnd p%0d c%0d x%0d", p, c, r), dut.u_regfile.regs[r], m_x[r]);
      end
      for (int i = 0; i < 16; i++)
        chk($sformatf("rnd p%0d dmem%0d", p, i), dut.u_dtcm.mem[i], m_d[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
